// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin mux sequencer.
// The select is 2 bits wide, so the source count is fixed at four.
package rr_mux_pkg;

    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        HOLD   = 2'd2
    } state_e;

    function automatic logic [NUM_SRC-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        idx_to_onehot      = '0;
        idx_to_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker over four requests.
// The search starts just after i_last_ptr and wraps from 3 to 0.
module rr_pick4
    import rr_mux_pkg::*;
(
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [NUM_SRC-1:0] i_mask,
    input  logic [SEL_W-1:0]   i_last_ptr,
    output logic [SEL_W-1:0]   o_winner,
    output logic               o_any
);

    logic [NUM_SRC-1:0] w_eligible;
    logic [SEL_W-1:0]   w_idx;

    assign w_eligible = i_req & ~i_mask;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    // Scanning from the farthest offset down lets the nearest eligible index win.
    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        w_idx    = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            w_idx = i_last_ptr + SEL_W'(k);
            if (w_eligible[w_idx]) begin
                o_winner = w_idx;
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_sequencer.sv
// Request-driven round-robin sequencer in front of a 4:1 mux: drives sel,
// captures mux_x one cycle later and offers it downstream via valid/ready.
module rr_mux_sequencer
    import rr_mux_pkg::*;
#(
    parameter int DATA_W  = 2,
    parameter int NUM_SRC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    output logic [NUM_SRC-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    input  logic [DATA_W-1:0]  mux_x,
    output logic [DATA_W-1:0]  out_data,
    output logic [SEL_W-1:0]   out_src,
    output logic               out_valid,
    input  logic               out_ready
);

    if (NUM_SRC != 4) begin : g_num_src_check
        $error("rr_mux_sequencer: NUM_SRC must be 4 to match the 2-bit mux select");
    end

    state_e             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_last_ptr;
    logic [NUM_SRC-1:0] r_grant;
    logic [DATA_W-1:0]  r_out_data;
    logic [SEL_W-1:0]   r_out_src;
    logic               r_out_valid;

    logic [SEL_W-1:0]   w_winner;
    logic               w_any;

    // A source whose grant is high right now cannot win again in the same cycle.
    rr_pick4 u_pick (
        .i_req      (req),
        .i_mask     (r_grant),
        .i_last_ptr (r_last_ptr),
        .o_winner   (w_winner),
        .o_any      (w_any)
    );

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_last_ptr  <= SEL_W'(NUM_SRC - 1);
            r_grant     <= '0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_grant <= '0;
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_sel   <= w_winner;
                        r_state <= SELECT;
                    end
                end
                SELECT: begin
                    // The mux has had a full cycle to settle on r_sel.
                    r_out_data  <= mux_x;
                    r_out_src   <= r_sel;
                    r_out_valid <= 1'b1;
                    r_grant     <= idx_to_onehot(r_sel);
                    r_last_ptr  <= r_sel;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_any) begin
                            r_sel   <= w_winner;
                            r_state <= SELECT;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant     = r_grant;
    assign sel       = r_sel;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign out_valid = r_out_valid;

endmodule
